// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
// Provides the operation encodings used on the sub input.
package cla_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Handshake bundle for cla_pipe_addsub: operation in, result out.
// master drives in_valid/a/b/cin/sub/out_ready; slave drives the rest.
interface cla_pipe_addsub_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_slice.sv
// Combinational K-bit carry-lookahead slice.
// In: a, b, ci. Out: s, co (slice carry-out), c_msb (carry into slice MSB).
module cla_slice #(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         ci,
    output logic [K-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [K-1:0] g;
    logic [K-1:0] p;
    logic [K:0]   c;
    logic         acc;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] as a flat sum of products: each g[j] masked by the
    // propagates above it, plus ci masked by all propagates below i+1.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b1;
        c[0] = ci;
        for (int i = 0; i < K; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
    end

    assign s     = p ^ c[K-1:0];
    assign co    = c[K];
    assign c_msb = c[K-1];
endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined N-bit CLA adder/subtractor, one K-bit slice per stage.
// Ports: clk, rst_n (async, active-low), bus (slave side of the handshake).
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int S = N / K;

    logic         adv;
    logic [N-1:0] b_eff;
    logic         cin_eff;
    logic [S-1:0] v_q;
    logic [S-1:0] c_q;
    logic [S-1:0] v_d;
    logic [S-1:0] c_d;
    logic [N-1:0] a_q [S];
    logic [N-1:0] b_q [S];
    logic [N-1:0] s_q [S];
    logic [N-1:0] a_d [S];
    logic [N-1:0] b_d [S];
    logic [N-1:0] s_d [S];
    logic         cm_last;
    logic         ovf_q;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv          = !v_q[S-1] || bus.out_ready;
    assign bus.in_ready = adv;

    assign b_eff   = bus.b ^ {N{bus.sub}};
    assign cin_eff = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

    for (genvar s = 0; s < S; s++) begin : g_stage
        logic [K-1:0] sa;
        logic [K-1:0] sb;
        logic [K-1:0] ss;
        logic         sci;
        logic         sco;
        logic         scm;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] ps;
        logic [N-1:0] pn;
        logic         vi;

        // Remaining operands are kept right-aligned so the next
        // slice always sits in the low K bits.
        if (s == 0) begin : g_head
            assign sa  = bus.a[K-1:0];
            assign sb  = b_eff[K-1:0];
            assign sci = cin_eff;
            assign ra  = bus.a >> K;
            assign rb  = b_eff >> K;
            assign ps  = '0;
            assign vi  = bus.in_valid;
        end else begin : g_body
            assign sa  = a_q[s-1][K-1:0];
            assign sb  = b_q[s-1][K-1:0];
            assign sci = c_q[s-1];
            assign ra  = a_q[s-1] >> K;
            assign rb  = b_q[s-1] >> K;
            assign ps  = s_q[s-1];
            assign vi  = v_q[s-1];
        end

        cla_slice #(.K(K)) u_slice (
            .a    (sa),
            .b    (sb),
            .ci   (sci),
            .s    (ss),
            .co   (sco),
            .c_msb(scm)
        );

        always_comb begin
            pn            = ps;
            pn[s*K +: K]  = ss;
        end

        assign v_d[s] = vi;
        assign c_d[s] = sco;
        assign a_d[s] = ra;
        assign b_d[s] = rb;
        assign s_d[s] = pn;

        if (s == S - 1) begin : g_tail
            assign cm_last = scm;
        end else begin : g_mid
            logic unused_cm;
            assign unused_cm = scm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < S; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= cm_last ^ c_d[S-1];
            for (int i = 0; i < S; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                s_q[i] <= s_d[i];
            end
        end
    end

    assign bus.out_valid = v_q[S-1];
    assign bus.sum       = s_q[S-1];
    assign bus.cout      = c_q[S-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: 16/4 main instance plus
// (8,8), (8,2), (32,4) sweep instances against an arithmetic model.
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] s, input logic co,
                                input logic ov);
        res_t r;
        r.sum  = s;
        r.cout = co;
        r.ovf  = ov;
        return r;
    endfunction

    // Unsigned result/carry and signed overflow from plain integer math.
    function automatic res_t model(input int n, input longint unsigned a,
                                   input longint unsigned b, input bit cin,
                                   input bit sub);
        longint unsigned full, m, u;
        longint half, sa, sb, sr;
        res_t r;
        r    = '0;
        full = 64'd1 << n;
        m    = full - 1;
        half = longint'(full >> 1);
        sa   = (a >= (full >> 1)) ? longint'(a) - longint'(full) : longint'(a);
        sb   = (b >= (full >> 1)) ? longint'(b) - longint'(full) : longint'(b);
        if (sub) begin
            u      = (a - b) & m;
            r.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            u      = a + b + 64'(cin);
            r.cout = (u > m);
            u      = u & m;
            sr     = sa + sb + longint'(cin);
        end
        r.ovf = (sr < -half) || (sr >= half);
        r.sum = u[31:0];
        return r;
    endfunction

    // ---------------- main 16/4 instance ----------------
    cla_pipe_addsub_if #(.N(16)) bus ();
    cla_pipe_addsub #(.N(16), .K(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    res_t q[$];
    int   pop_cycles[$];
    int   pops = 0;
    int   rmode = 0;
    int   hold = 0;
    logic stall_prev = 1'b0;
    logic [15:0] p_sum;
    logic p_cout, p_ovf;
    res_t m_e;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rmode == 0) bus.out_ready = 1'b1;
            else if (rmode == 1) bus.out_ready = 1'b0;
            else if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else if ($urandom_range(0, 3) == 0) begin
                hold = $urandom_range(0, 5);
                bus.out_ready = 1'b0;
            end else bus.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_adv", bus.in_ready,
                !bus.out_valid || bus.out_ready);
            if (stall_prev) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_sum", bus.sum, p_sum);
                chk("stall_cout", bus.cout, p_cout);
                chk("stall_ovf", bus.ovf, p_ovf);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("unexpected_out", bus.out_valid, 0);
                else begin
                    m_e = q.pop_front();
                    chk("sum", bus.sum, m_e.sum[15:0]);
                    chk("cout", bus.cout, m_e.cout);
                    chk("ovf", bus.ovf, m_e.ovf);
                    pops++;
                    pop_cycles.push_back(cyc);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            p_sum  = bus.sum;
            p_cout = bus.cout;
            p_ovf  = bus.ovf;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input bit cin, input bit sub, input res_t e);
        int tries = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.sub = sub;
        #1;
        while (!bus.in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
        else q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] a, b;
        bit ci, sb;
        a  = 16'($urandom);
        b  = 16'($urandom);
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        send(a, b, ci, sb, model(16, a, b, ci, sb));
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (q.size() > 0 && i < budget) begin
            @(negedge clk);
            #2;
            i++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // ---------------- parameter sweep ----------------
    bit sweep_go = 1'b0;
    int sw_count = 0;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int NN = (g == 2) ? 32 : 8;
        localparam int KK = (g == 0) ? 8 : (g == 1) ? 2 : 4;
        localparam int SS = NN / KK;

        cla_pipe_addsub_if #(.N(NN)) sbus ();
        cla_pipe_addsub #(.N(NN), .K(KK)) sdut (
            .clk  (clk),
            .rst_n(sw_rst_n),
            .bus  (sbus)
        );

        res_t sq[$];
        int   spops = 0;
        res_t s_e;

        always @(negedge clk) begin
            #1;
            if (sw_rst_n && sbus.out_valid && sbus.out_ready) begin
                if (sq.size() == 0)
                    chk($sformatf("sw%0d_unexpected", g), sbus.out_valid, 0);
                else begin
                    s_e = sq.pop_front();
                    chk($sformatf("sw%0d_sum", g), sbus.sum, s_e.sum[NN-1:0]);
                    chk($sformatf("sw%0d_cout", g), sbus.cout, s_e.cout);
                    chk($sformatf("sw%0d_ovf", g), sbus.ovf, s_e.ovf);
                    spops++;
                end
            end
        end

        initial begin : sw_main
            logic [NN-1:0] cv [3];
            int lat, tries, k, w;
            sbus.in_valid  = 1'b0;
            sbus.a         = '0;
            sbus.b         = '0;
            sbus.cin       = 1'b0;
            sbus.sub       = 1'b0;
            sbus.out_ready = 1'b1;
            cv[0] = '0;
            cv[1] = '1;
            cv[2] = '0;
            cv[2][NN-1] = 1'b1;
            wait (sweep_go);
            @(negedge clk);
            #1 chk($sformatf("sw%0d_rst_valid", g), sbus.out_valid, 0);
            k = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    for (int m = 0; m < 4; m++) begin
                        @(negedge clk);
                        sbus.in_valid = 1'b1;
                        sbus.a   = cv[i];
                        sbus.b   = cv[j];
                        sbus.sub = m[1];
                        sbus.cin = m[0];
                        #1 tries = 0;
                        while (!sbus.in_ready && tries < 50) begin
                            @(negedge clk);
                            #1 tries++;
                        end
                        if (!sbus.in_ready)
                            chk($sformatf("sw%0d_in_ready", g), sbus.in_ready, 1);
                        else
                            sq.push_back(model(NN, cv[i], cv[j], m[0], m[1]));
                        @(posedge clk);
                        #1 sbus.in_valid = 1'b0;
                        if (k == 0) begin
                            lat = 0;
                            while (lat < 40) begin
                                @(negedge clk);
                                lat++;
                                if (sbus.out_valid) break;
                            end
                            chk($sformatf("sw%0d_latency", g), lat, SS);
                        end
                        k++;
                    end
            w = 0;
            while (sq.size() > 0 && w < 100) begin
                @(negedge clk);
                #2 w++;
            end
            chk($sformatf("sw%0d_drain", g), sq.size(), 0);
            chk($sformatf("sw%0d_count", g), spops, 36);
            sw_count++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, p0, n, w;
        rst_n        = 1'b0;
        sw_rst_n     = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        send(16'hFFFF, 16'h0001, 1'b0, OP_ADD, mk(32'h0000, 1'b1, 1'b0));
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        chk("t1_latency", lat, 4);
        drain(20);

        send(16'h8000, 16'h0001, 1'b0, OP_SUB, mk(32'h7FFF, 1'b1, 1'b1));
        send(16'h0001, 16'h0002, 1'b1, OP_SUB, mk(32'hFFFF, 1'b0, 1'b0));
        drain(20);

        pop_cycles.delete();
        for (int i = 0; i < 20; i++) send_rand();
        drain(40);
        chk("stream_count", pop_cycles.size(), 20);
        if (pop_cycles.size() == 20)
            chk("stream_consec", pop_cycles[19] - pop_cycles[0], 19);

        rmode = 2;
        p0 = pops;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_rand();
            n++;
        end
        drain(400);
        chk("bp_count", pops - p0, n);
        rmode = 0;
        repeat (2) @(negedge clk);

        rmode = 1;
        send(16'hFFFF, 16'hFFFF, 1'b0, OP_ADD, mk(32'hFFFE, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) send_rand();
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_cout", bus.cout, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h5555;
        bus.b = 16'h1111;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        rmode = 0;
        p0 = pops;
        send(16'h1234, 16'h1111, 1'b1, OP_ADD, mk(32'h2346, 1'b0, 1'b0));
        drain(20);
        repeat (8) @(negedge clk);
        chk("post_rst_count", pops - p0, 1);

        sweep_go = 1'b1;
        w = 0;
        while (sw_count < 3 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("sweep_done", sw_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
